// File: rtl/cv32e40x_mult_issue.sv
// ----------------------------------------------------------------------------
// cv32e40x_mult_issue
//
// Issue stage directly upstream of the integer multiplier. Accepts decoded
// multiply / carry-less-multiply requests over a valid/ready handshake,
// decodes them once at acceptance, holds them, and drives the multiplier
// inputs from the head entry until the multiplier accepts (mult_ready_i).
// A held entry never changes while valid, because MULH re-reads the operands
// on four consecutive cycles.
//
// Configuration macro:
//   MULT_ISSUE_SKID_EN  defined   -> 2-entry FIFO (head + skid), registered
//                                    in_ready_o (no path from mult_ready_i)
//                       undefined -> single entry, in_ready_o combinational
//                                    from mult_ready_i
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid_i/ready_o  request handshake from ID/EX
//   in_op_i             000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 CLMUL
//   in_rs1_i/in_rs2_i   operands A/B
//   kill_i              flush all held requests (wins over accept)
//   illegal_o           one-cycle pulse after an illegal op is accepted
//   busy_o              at least one request held
//   mult_*_o            multiplier valid_i/operator_i/signed_mode_i/op_a_i/op_b_i
//   mult_ready_i        multiplier ready_o; head retires on valid && ready
// ----------------------------------------------------------------------------

package cv32e40x_mult_issue_pkg;

    typedef enum logic [1:0] {
        MUL_M32     = 2'b00,
        MUL_H       = 2'b01,
        MUL_B_CLMUL = 2'b10
    } mul_opcode_e;

    // One held request, already decoded for the multiplier.
    typedef struct packed {
        mul_opcode_e op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } head_state_e;

endpackage

module cv32e40x_mult_issue
    import cv32e40x_mult_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  in_op_i,
    input  logic [31:0] in_rs1_i,
    input  logic [31:0] in_rs2_i,

    input  logic        kill_i,
    output logic        illegal_o,
    output logic        busy_o,

    output logic        mult_valid_o,
    output mul_opcode_e mult_operator_o,
    output logic [1:0]  mult_signed_mode_o,
    output logic [31:0] mult_op_a_o,
    output logic [31:0] mult_op_b_o,
    input  logic        mult_ready_i
);

    entry_t dec_entry;
    logic   dec_legal;
    logic   accept;
    logic   push;
    logic   retire;
    logic   illegal_q;
    logic   head_valid;
    entry_t head;

    // ------------------------------------------------------------------
    // Decode at acceptance
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned (which would infer a latch).
    always_comb begin
        dec_legal      = 1'b1;
        dec_entry.op   = MUL_M32;
        dec_entry.mode = 2'b00;
        dec_entry.a    = in_rs1_i;
        dec_entry.b    = in_rs2_i;
        case (in_op_i)
            3'b000: ;                                                  // MUL
            3'b001: begin dec_entry.op = MUL_H; dec_entry.mode = 2'b11; end  // MULH
            3'b010: begin dec_entry.op = MUL_H; dec_entry.mode = 2'b01; end  // MULHSU
            3'b011: begin dec_entry.op = MUL_H; dec_entry.mode = 2'b00; end  // MULHU
            3'b100: dec_entry.op = MUL_B_CLMUL;                        // CLMUL
            default: dec_legal = 1'b0;
        endcase
    end

    // Illegal ops complete the handshake but are never stored.
    assign accept = in_valid_i && in_ready_o;
    assign push   = accept && dec_legal;
    assign retire = mult_valid_o && mult_ready_i;

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together at the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !dec_legal;
        end
    end

    assign illegal_o = illegal_q;

`ifdef MULT_ISSUE_SKID_EN
    // ------------------------------------------------------------------
    // Two-entry FIFO: head + skid slot, 1-bit wrap-around pointers.
    // ------------------------------------------------------------------
    entry_t     entries [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       ready_q;

    // ready_q is "not full" registered from the next-cycle occupancy, so
    // mult_ready_i never reaches in_ready_o combinationally.
    assign in_ready_o = ready_q && !kill_i;

    always_comb begin
        count_d = count_q;
        case ({push, retire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (kill_i) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
            if (kill_i) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= !wr_ptr_q;
                end
                if (retire) begin
                    rd_ptr_q <= !rd_ptr_q;
                end
            end
        end
    end

    // NOTE: the payload storage has no reset; its contents are only
    // observed through head_valid, which is reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr_q] <= dec_entry;
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head       = entries[rd_ptr_q];

`else
    // ------------------------------------------------------------------
    // Single entry with EMPTY/HELD head state machine.
    // ------------------------------------------------------------------
    head_state_e state_q;
    head_state_e state_d;
    entry_t      entry_q;

    // A new request may enter in the same cycle the held one retires,
    // which keeps mult_valid_o high with no bubble.
    assign in_ready_o = ((state_q == EMPTY) || retire) && !kill_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = HELD;
            HELD:    if (retire && !push) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (kill_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // push is only possible when empty or retiring, so a valid entry is
    // never overwritten while the multiplier is still reading it.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q <= dec_entry;
        end
    end

    assign head_valid = (state_q == HELD);
    assign head       = entry_q;
`endif

    // ------------------------------------------------------------------
    // Multiplier drive. Kill drops valid combinationally so the multiplier
    // returns to ALBL and clears its accumulator in the kill cycle.
    // ------------------------------------------------------------------
    assign busy_o             = head_valid;
    assign mult_valid_o       = head_valid && !kill_i;
    assign mult_operator_o    = head_valid ? head.op   : MUL_M32;
    assign mult_signed_mode_o = head_valid ? head.mode : 2'b00;
    assign mult_op_a_o        = head_valid ? head.a    : 32'd0;
    assign mult_op_b_o        = head_valid ? head.b    : 32'd0;

endmodule
